mem_byte_ctrl: RTL
==================

// Module: mem_byte_ctrl
// PURPOSE
//  Memory-side controller directly downstream of the data cache. It accepts one
//  32-bit word request at a time from the cache's RAM port and serialises it onto
//  an 8-bit asynchronous external SRAM bus, with a programmable number of wait
//  states per byte. It returns the assembled read word plus a one-cycle
//  ram_data_ready pulse, which the cache consumes to fill or evict a line.
// PARAMETERS
//  ADDR_W       19  external byte-address width; ext_addr_o = ram_addr_i[ADDR_W-1:0] with bits [1:0] replaced
//  WAIT_CYCLES  1   wait states per byte phase (0..15); a byte phase lasts WAIT_CYCLES+1 cycles
// PORTS
//  clk             in   1       system clock, all state on rising edge
//  rst             in   1       asynchronous, active-low reset (0 = reset)
//  ram_ce_i        in   1       request valid (`ChipEnable)
//  ram_we_i        in   1       1 = write, 0 = read
//  ram_sel_i       in   4       byte enables for writes; ignored for reads
//  ram_addr_i      in   32      word address; bits [1:0] ignored
//  ram_data_i      in   32      write data
//  ram_data_o      out  32      read word, valid while ram_data_ready=1, then held
//  ram_data_ready  out  1       one-cycle completion pulse (reads and writes)
//  ext_addr_o      out  ADDR_W  external byte address
//  ext_data_o      out  8       external write byte
//  ext_data_i      in   8       external read byte
//  ext_ce_n_o      out  1       external chip enable, active-low
//  ext_oe_n_o      out  1       external output enable, active-low (reads)
//  ext_we_n_o      out  1       external write enable, active-low (writes)
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE; ram_data_o=0, ram_data_ready=0, ext_addr_o=0,
//   ext_data_o=0, ext_ce_n_o/ext_oe_n_o/ext_we_n_o=1 immediately, no clock needed.
//   Reset mid-transfer aborts it; no ready pulse is issued for the aborted request.
//  FSM: IDLE -> XFER -> DONE -> IDLE.
//   IDLE: on the edge with ram_ce_i=1, latch we/sel/addr/data, byte index k=0, go to XFER.
//   XFER: byte k at ext_addr_o={addr[ADDR_W-1:2],k[1:0]}; little-endian, byte k <-> data[8k+7:8k].
//    Phase counter runs 0..WAIT_CYCLES; ext_ce_n_o=0 for the whole phase.
//    Read: ext_oe_n_o=0; ext_data_i is captured into byte k on the last cycle of the phase.
//    Write: ext_we_n_o=0 for all cycles of the phase except the last, which is the hold cycle
//     (with WAIT_CYCLES=0, we_n is low for the single cycle); ext_data_o is stable for the phase.
//    Reads always transfer all 4 bytes. Writes skip bytes whose sel bit is 0, with no cycles spent on them.
//    After the last required byte, go to DONE.
//   DONE: ram_data_ready=1 for exactly one cycle; ram_data_o updated for reads. Go to IDLE.
//  Latency: read with N=4 bytes, or write with N=popcount(sel) bytes:
//   ready is asserted N*(WAIT_CYCLES+1)+1 cycles after the accept edge.
//  A write with sel=4'b0000 goes IDLE->DONE, and ready is asserted 1 cycle after accept.
//  The request is latched. ram_ce_i or any input changing after accept has no effect; the
//   transfer completes and ready still pulses.
//  A new request is sampled only in IDLE. Back-to-back requests therefore see one idle cycle
//   after DONE; ram_ce_i held high is re-accepted on that IDLE edge.
//  Outside XFER: ext_ce_n_o, ext_oe_n_o and ext_we_n_o are all 1. oe_n and we_n are never 0
//   in the same cycle.
// CONFIGURATION
//  MEM_BYTE_CTRL_LASTRD_EN defined: one-entry last-read buffer (word address + data + valid).
//   A read whose word address equals the buffered address while valid=1 goes IDLE->DONE
//    with no external access; ready is asserted 1 cycle after accept, ram_data_o = buffered word.
//   Every completed read refills the buffer. Any accepted write, even with sel=0, clears valid.
//   Reset clears valid.
//  MEM_BYTE_CTRL_LASTRD_EN undefined: no buffer; every read performs the full 4-byte external access.
// TESTING
//  1 Read, WAIT_CYCLES=1, addr=0x00000010, ext bytes 0x10..0x13 = 11,22,33,44 -> ext_addr_o steps
//    0x10,0x11,0x12,0x13 for 2 cycles each; ready pulses at cycle 9 after accept; ram_data_o=0x44332211.
//  2 Write, sel=4'b1010, data=0xAABBCCDD, addr=0x20 -> exactly two phases, at 0x21 (0xCC) then
//    0x23 (0xAA); ready at cycle 5 (WAIT_CYCLES=1).
//  3 Write, sel=4'b0000 -> no ext_ce_n_o low; ready 1 cycle after accept.
//  4 rst=0 asserted mid-write, between clock edges -> ext_we_n_o/ext_ce_n_o go to 1
//    asynchronously; no ready pulse; the next read completes normally.
//  5 ram_ce_i held high for two reads (0x40, 0x44) -> each completes; one IDLE cycle between DONE and
//    the next XFER; ram_data_o held between pulses.
//  6 LASTRD_EN: read 0x40 twice -> second has ready 1 cycle after accept with the same data;
//    write 0x40 then read 0x40 -> full external read.

Source files
------------

// File: rtl/mem_byte_ctrl_if.sv
// rtl/mem_byte_ctrl_if.sv - cache RAM port and 8-bit external SRAM bus bundle for mem_byte_ctrl
interface mem_byte_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic              ram_ce_i;
  logic              ram_we_i;
  logic [3:0]        ram_sel_i;
  logic [31:0]       ram_addr_i;
  logic [31:0]       ram_data_i;
  logic [31:0]       ram_data_o;
  logic              ram_data_ready;
  logic [ADDR_W-1:0] ext_addr_o;
  logic [7:0]        ext_data_o;
  logic [7:0]        ext_data_i;
  logic              ext_ce_n_o;
  logic              ext_oe_n_o;
  logic              ext_we_n_o;

  modport slave (
    input  ram_ce_i, ram_we_i, ram_sel_i, ram_addr_i, ram_data_i, ext_data_i,
    output ram_data_o, ram_data_ready, ext_addr_o, ext_data_o, ext_ce_n_o, ext_oe_n_o, ext_we_n_o
  );

  modport master (
    output ram_ce_i, ram_we_i, ram_sel_i, ram_addr_i, ram_data_i, ext_data_i,
    input  ram_data_o, ram_data_ready, ext_addr_o, ext_data_o, ext_ce_n_o, ext_oe_n_o, ext_we_n_o
  );
endinterface

// File: rtl/mem_byte_ctrl.sv
// rtl/mem_byte_ctrl.sv - 32-bit word to 8-bit async SRAM serialiser with per-byte wait states
// Optional last-read buffer enabled by defining MEM_BYTE_CTRL_LASTRD_EN.
module mem_byte_ctrl #(
  parameter int ADDR_W      = 19,
  parameter int WAIT_CYCLES = 1
) (
  input logic            clk,
  input logic            rst,
  mem_byte_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] PH_LAST = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [ADDR_W-1:2] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        k_q, k_d;
  logic [3:0]        ph_q, ph_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              lr_hit;
  logic [31:0]       lr_word;
  logic              fill;
  logic [2:0]        first_b;
  logic [2:0]        next_b;
  logic              xfer;
  logic              unused_in;

  // {none_found, index} of the lowest set bit in mask
  function automatic logic [2:0] first_sel(input logic [3:0] mask);
    logic [2:0] r;
    r = 3'b100;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) r = {1'b0, 2'(i)};
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    k_d     = k_q;
    ph_d    = ph_q;
    asm_d   = asm_q;
    rdata_d = rdata_q;
    fill    = 1'b0;
    first_b = 3'b100;
    next_b  = 3'b100;
    case (state_q)
      S_IDLE: begin
        if (bus.ram_ce_i) begin
          we_d    = bus.ram_we_i;
          // reads always move all four bytes, so treat them as sel=1111
          sel_d   = bus.ram_we_i ? bus.ram_sel_i : 4'hF;
          addr_d  = bus.ram_addr_i[ADDR_W-1:2];
          wdata_d = bus.ram_data_i;
          ph_d    = 4'd0;
          first_b = first_sel(sel_d);
          if (lr_hit) begin
            rdata_d = lr_word;
            state_d = S_DONE;
          end else if (first_b[2]) begin
            state_d = S_DONE;
          end else begin
            k_d     = first_b[1:0];
            state_d = S_XFER;
          end
        end
      end
      S_XFER: begin
        if (ph_q == PH_LAST) begin
          if (!we_q) asm_d[8*k_q +: 8] = bus.ext_data_i;
          ph_d   = 4'd0;
          next_b = first_sel(sel_q & (4'b1110 << k_q));
          if (next_b[2]) begin
            state_d = S_DONE;
            if (!we_q) begin
              rdata_d = asm_d;
              fill    = 1'b1;
            end
          end else begin
            k_d = next_b[1:0];
          end
        end else begin
          ph_d = ph_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      k_q     <= 2'd0;
      ph_q    <= 4'd0;
      asm_q   <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      k_q     <= k_d;
      ph_q    <= ph_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_BYTE_CTRL_LASTRD_EN
  logic        lr_valid_q;
  logic [29:0] lr_addr_q;
  logic [29:0] rd_waddr_q;
  logic [31:0] lr_data_q;

  assign lr_hit  = bus.ram_ce_i && !bus.ram_we_i && lr_valid_q &&
                   (bus.ram_addr_i[31:2] == lr_addr_q);
  assign lr_word = lr_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lr_valid_q <= 1'b0;
      lr_addr_q  <= 30'd0;
      rd_waddr_q <= 30'd0;
      lr_data_q  <= 32'd0;
    end else begin
      if (state_q == S_IDLE && bus.ram_ce_i) begin
        rd_waddr_q <= bus.ram_addr_i[31:2];
        if (bus.ram_we_i) lr_valid_q <= 1'b0;
      end
      // a buffer hit needs no refill: its contents are already current
      if (fill) begin
        lr_valid_q <= 1'b1;
        lr_addr_q  <= rd_waddr_q;
        lr_data_q  <= rdata_d;
      end
    end
  end
`else
  assign lr_hit  = 1'b0;
  assign lr_word = 32'd0;
`endif

  assign unused_in = ^{bus.ram_addr_i, fill};

  assign xfer               = (state_q == S_XFER);
  assign bus.ext_ce_n_o     = !xfer;
  assign bus.ext_oe_n_o     = !(xfer && !we_q);
  // last cycle of a write phase is the hold cycle unless the phase is a single cycle
  assign bus.ext_we_n_o     = !(xfer && we_q && ((PH_LAST == 4'd0) || (ph_q != PH_LAST)));
  assign bus.ext_addr_o     = {addr_q, k_q};
  assign bus.ext_data_o     = wdata_q[8*k_q +: 8];
  assign bus.ram_data_o     = rdata_q;
  assign bus.ram_data_ready = (state_q == S_DONE);
endmodule
